// File: rtl/reloj_alarmas_param.sv
// Wall-clock timekeeping core: prescaled hh:mm:ss counter, NUM_ALARMS alarm registers,
// ring/snooze FSM and a 12/24 h display view for the external digit multiplexer.
module reloj_alarmas_param #(
   parameter int CLK_HZ     = 50000000,
   parameter int NUM_ALARMS = 4,
   parameter int ASEL_W     = 2,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_S     = 60
) (
   input  logic                  clock,
   input  logic                  Reset,
   input  logic                  mode_12h,
   input  logic                  set_time,
   input  logic                  set_alarm,
   input  logic [ASEL_W-1:0]     alarm_sel,
   input  logic                  inc_min,
   input  logic                  inc_hour,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   input  logic                  snooze,
   input  logic                  stop,
   output logic                  sec_tick,
   output logic                  seg_led,
   output logic [4:0]            disp_hour,
   output logic [5:0]            disp_min,
   output logic [5:0]            disp_sec,
   output logic                  pm,
   output logic                  ringing,
   output logic                  snoozed,
   output logic [ASEL_W-1:0]     alarm_src
);
   localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int SNZ_S = SNOOZE_MIN * 60;
   localparam int SW    = $clog2(SNZ_S + 1);
   localparam int RW    = $clog2(RING_S + 1);
   localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

   logic [PW-1:0] presc;
   logic [5:0]    cur_sec, cur_min, min_nx, sec_nx;
   logic [4:0]    cur_hour, hour_nx;
   logic          sec_wrap, min_wrap;
   logic          min_q, hour_q, snz_q, min_up, hour_up, snz_up;
   logic [NUM_ALARMS-1:0][4:0] alarm_h;
   logic [NUM_ALARMS-1:0][5:0] alarm_m;
   logic [4:0]    sel_h, raw_h;
   logic [5:0]    sel_m;
   logic          show_alarm, match_any, match;
   logic [ASEL_W-1:0] match_idx, src_n;
   state_t        state, state_n;
   logic [RW-1:0] ring_cnt, ring_n;
   logic [SW-1:0] snz_cnt, snz_n;

   assign min_up   = inc_min  & ~min_q;
   assign hour_up  = inc_hour & ~hour_q;
   assign snz_up   = snooze   & ~snz_q;
   assign sec_tick = ~set_time & (presc == PRESC_TC);

   // Carry chain: the value time takes on the next sec_tick.
   assign sec_wrap = (cur_sec == 6'd59);
   assign min_wrap = (cur_min == 6'd59);
   assign sec_nx   = sec_wrap ? 6'd0 : cur_sec + 6'd1;
   assign min_nx   = sec_wrap ? (min_wrap ? 6'd0 : cur_min + 6'd1) : cur_min;
   assign hour_nx  = (sec_wrap && min_wrap) ?
                     ((cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1) : cur_hour;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         presc    <= '0;
         cur_sec  <= '0;
         cur_min  <= '0;
         cur_hour <= '0;
         seg_led  <= 1'b0;
         min_q    <= 1'b0;
         hour_q   <= 1'b0;
         snz_q    <= 1'b0;
      end else begin
         min_q  <= inc_min;
         hour_q <= inc_hour;
         snz_q  <= snooze;
         if (set_time) begin
            presc   <= '0;
            cur_sec <= '0;
            if (min_up)  cur_min  <= min_wrap ? 6'd0 : cur_min + 6'd1;
            if (hour_up) cur_hour <= (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
         end else begin
            presc <= sec_tick ? '0 : presc + PW'(1);
            if (sec_tick) begin
               cur_sec  <= sec_nx;
               cur_min  <= min_nx;
               cur_hour <= hour_nx;
               seg_led  <= ~seg_led;
            end
         end
      end
   end

   assign show_alarm = set_alarm & ~set_time;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         alarm_h <= '0;
         alarm_m <= '0;
      end else if (show_alarm) begin
         for (int i = 0; i < NUM_ALARMS; i++)
            if (alarm_sel == ASEL_W'(i)) begin
               if (min_up)  alarm_m[i] <= (alarm_m[i] == 6'd59) ? 6'd0 : alarm_m[i] + 6'd1;
               if (hour_up) alarm_h[i] <= (alarm_h[i] == 5'd23) ? 5'd0 : alarm_h[i] + 5'd1;
            end
      end
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
         if (alarm_en[i] && alarm_h[i] == hour_nx && alarm_m[i] == min_nx) begin
            match_any = 1'b1;
            match_idx = ASEL_W'(i);
         end
   end
   assign match = match_any & sec_tick & sec_wrap & ~set_time & ~set_alarm;

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         ring_cnt  <= '0;
         snz_cnt   <= '0;
         alarm_src <= '0;
      end else begin
         state     <= state_n;
         ring_cnt  <= ring_n;
         snz_cnt   <= snz_n;
         alarm_src <= src_n;
      end
   end

   always_comb begin
      state_n = state;
      ring_n  = ring_cnt;
      snz_n   = snz_cnt;
      src_n   = alarm_src;
      case (state)
         IDLE:
            if (match) begin
               state_n = RINGING;
               ring_n  = RW'(RING_S);
               src_n   = match_idx;
            end
         RINGING:
            if (stop) state_n = IDLE;
            else if (match) begin
               ring_n = RW'(RING_S);
               src_n  = match_idx;
            end else if (snz_up) begin
               state_n = SNOOZED;
               snz_n   = SW'(SNZ_S);
            end else if (sec_tick) begin
               if (ring_cnt <= RW'(1)) state_n = IDLE;
               else                    ring_n  = ring_cnt - RW'(1);
            end
         SNOOZED:
            if (stop) state_n = IDLE;
            else if (match) begin
               state_n = RINGING;
               ring_n  = RW'(RING_S);
               src_n   = match_idx;
            end else if (sec_tick) begin
               if (snz_cnt <= SW'(1)) begin
                  state_n = RINGING;
                  ring_n  = RW'(RING_S);
               end else snz_n = snz_cnt - SW'(1);
            end
         default: state_n = IDLE;
      endcase
   end

   assign ringing = (state == RINGING);
   assign snoozed = (state == SNOOZED);

   always_comb begin
      sel_h = '0;
      sel_m = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         if (alarm_sel == ASEL_W'(i)) begin
            sel_h = alarm_h[i];
            sel_m = alarm_m[i];
         end
   end

   assign raw_h    = show_alarm ? sel_h : cur_hour;
   assign disp_min = show_alarm ? sel_m : cur_min;
   assign disp_sec = set_alarm ? 6'd0 : cur_sec;

   always_comb begin
      disp_hour = raw_h;
      pm        = 1'b0;
      if (mode_12h) begin
         pm = (raw_h >= 5'd12);
         if (raw_h == 5'd0)       disp_hour = 5'd12;
         else if (raw_h > 5'd12)  disp_hour = raw_h - 5'd12;
      end
   end
endmodule

// File: tb/tb_reloj_alarmas_param.sv
// Directed bench for reloj_alarmas_param with a fast prescaler, short ring and one-minute snooze.
module tb_reloj_alarmas_param;
   logic       clock, Reset;
   logic       mode_12h, set_time, set_alarm, inc_min, inc_hour, snooze, stop;
   logic [1:0] alarm_sel;
   logic [3:0] alarm_en;
   logic       sec_tick, seg_led, pm, ringing, snoozed;
   logic [4:0] disp_hour;
   logic [5:0] disp_min, disp_sec;
   logic [1:0] alarm_src;

   int nvec = 0;
   int nerr = 0;

   reloj_alarmas_param #(.CLK_HZ(4), .NUM_ALARMS(4), .ASEL_W(2), .SNOOZE_MIN(1), .RING_S(3)) dut (
      .clock(clock), .Reset(Reset), .mode_12h(mode_12h), .set_time(set_time),
      .set_alarm(set_alarm), .alarm_sel(alarm_sel), .inc_min(inc_min), .inc_hour(inc_hour),
      .alarm_en(alarm_en), .snooze(snooze), .stop(stop), .sec_tick(sec_tick),
      .seg_led(seg_led), .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
      .pm(pm), .ringing(ringing), .snoozed(snoozed), .alarm_src(alarm_src));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int         incs;
      logic       mode;
      logic [4:0] eh;
      logic       epm;
   } hv_t;
   hv_t tbl [0:10];

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_min();
      inc_min = 1'b1; step(1); inc_min = 1'b0; step(1);
   endtask

   task automatic pulse_hour();
      inc_hour = 1'b1; step(1); inc_hour = 1'b0; step(1);
   endtask

   task automatic wait_tick();
      int n = 0;
      while (sec_tick !== 1'b1 && n < 16) begin step(1); n++; end
      if (sec_tick !== 1'b1) begin
         nvec++; nerr++;
         $display("FAIL tick_timeout: got no sec_tick within 16 cycles");
      end
      step(1);
   endtask

   task automatic wait_ring(input int lim, input string name);
      int n = 0;
      while (ringing !== 1'b1 && n < lim) begin step(1); n++; end
      chk(name, ringing, 1);
   endtask

   task automatic chk_time(input string name, input int h, input int m, input int s);
      chk({name, "_h"}, disp_hour, h);
      chk({name, "_m"}, disp_min, m);
      chk({name, "_s"}, disp_sec, s);
   endtask

   initial begin
      int ticks, first;
      tbl[0]  = '{0,  1'b1, 5'd12, 1'b0};
      tbl[1]  = '{0,  1'b0, 5'd0,  1'b0};
      tbl[2]  = '{1,  1'b1, 5'd1,  1'b0};
      tbl[3]  = '{10, 1'b1, 5'd11, 1'b0};
      tbl[4]  = '{1,  1'b1, 5'd12, 1'b1};
      tbl[5]  = '{0,  1'b0, 5'd12, 1'b0};
      tbl[6]  = '{1,  1'b1, 5'd1,  1'b1};
      tbl[7]  = '{0,  1'b0, 5'd13, 1'b0};
      tbl[8]  = '{10, 1'b1, 5'd11, 1'b1};
      tbl[9]  = '{0,  1'b0, 5'd23, 1'b0};
      tbl[10] = '{1,  1'b1, 5'd12, 1'b0};

      {mode_12h, set_time, set_alarm, inc_min, inc_hour, snooze, stop} = '0;
      alarm_sel = '0; alarm_en = '0;
      Reset = 1'b1;
      #2 Reset = 1'b0;
      step(2);
      chk_time("reset", 0, 0, 0);
      chk("reset_tick", sec_tick, 0);
      chk("reset_led", seg_led, 0);
      chk("reset_ring", {ringing, snoozed, pm}, 0);
      chk("reset_src", alarm_src, 0);

      // Free run: 244 cycles at 4 cycles per second.
      Reset = 1'b1;
      ticks = 0; first = 0;
      for (int k = 0; k < 244; k++) begin
         step(1);
         if (sec_tick === 1'b1) begin
            ticks++;
            if (first == 0) first = k + 1;
         end
      end
      chk("tick_count", ticks, 61);
      chk("first_tick", first, 3);
      chk("led_after_61", seg_led, 1);
      chk_time("run244", 0, 1, 1);

      // Set-time mode: seconds cleared, then the 12/24 h table.
      set_time = 1'b1;
      step(1);
      chk_time("set_entry", 0, 1, 0);
      for (int i = 0; i <= 10; i++) begin
         repeat (tbl[i].incs) pulse_hour();
         mode_12h = tbl[i].mode;
         step(1);
         chk($sformatf("tbl%0d_hour", i), disp_hour, tbl[i].eh);
         chk($sformatf("tbl%0d_pm", i), pm, tbl[i].epm);
      end
      mode_12h = 1'b0;
      repeat (58) pulse_min();
      chk("min59", disp_min, 59);
      pulse_min();
      chk_time("min_wrap_nocarry", 0, 0, 0);
      repeat (59) pulse_min();
      repeat (23) pulse_hour();
      chk_time("preload", 23, 59, 0);
      set_time = 1'b0;
      step(4 * 58);
      chk_time("run58", 23, 59, 58);
      mode_12h = 1'b1;
      step(4);
      chk_time("t235959_12h", 11, 59, 59);
      chk("t235959_pm", pm, 1);
      step(4);
      chk_time("midnight_12h", 12, 0, 0);
      chk("midnight_pm", pm, 0);
      mode_12h = 1'b0;
      #1;
      chk("midnight_24h", disp_hour, 0);

      // Alarm 2 at 00:02, ring lasts three ticks.
      set_alarm = 1'b1; alarm_sel = 2'd2;
      pulse_min(); pulse_min();
      chk_time("alarm2_view", 0, 2, 0);
      alarm_sel = 2'd3;
      #1;
      chk("alarm3_view", disp_min, 0);
      set_alarm = 1'b0; alarm_en = 4'b0100;
      wait_ring(600, "alarm2_ring");
      chk("alarm2_src", alarm_src, 2);
      chk_time("alarm2_time", 0, 2, 0);
      wait_tick(); wait_tick();
      chk("ring_after2", ringing, 1);
      wait_tick();
      chk("ring_after3", ringing, 0);

      // Back to 00:00:00, alarms 1 and 3 at 00:01.
      set_time = 1'b1;
      step(1);
      repeat (58) pulse_min();
      chk_time("rewind", 0, 0, 0);
      set_time = 1'b0; set_alarm = 1'b1; alarm_sel = 2'd1;
      pulse_min();
      alarm_sel = 2'd3;
      pulse_min();
      chk("alarm3_prog", disp_min, 1);
      set_alarm = 1'b0; alarm_en = 4'b1010;
      wait_ring(400, "dual_ring");
      chk("dual_src", alarm_src, 1);
      chk_time("dual_time", 0, 1, 0);
      alarm_en = 4'b0000;
      wait_tick();
      chk("ring_after_disable", ringing, 1);

      // Snooze for 60 ticks, then stop and snooze together.
      snooze = 1'b1; step(1); snooze = 1'b0;
      chk("snz_state", {ringing, snoozed}, 2'b01);
      repeat (59) wait_tick();
      chk("snz_59", {ringing, snoozed}, 2'b01);
      wait_tick();
      chk("snz_60", {ringing, snoozed}, 2'b10);
      snooze = 1'b1; stop = 1'b1;
      step(1);
      snooze = 1'b0; stop = 1'b0;
      chk("stop_snz", {ringing, snoozed}, 2'b00);

      // Async reset in the middle of ringing.
      Reset = 1'b0; step(1); Reset = 1'b1;
      chk_time("reset2", 0, 0, 0);
      alarm_en = 4'b0001; set_alarm = 1'b1; alarm_sel = 2'd0;
      pulse_min();
      set_alarm = 1'b0;
      wait_ring(400, "alarm0_ring");
      #1 Reset = 1'b0;
      #1;
      chk("async_ring", ringing, 0);
      chk_time("async_time", 0, 0, 0);
      set_alarm = 1'b1;
      #1;
      chk("async_alarm0", disp_min, 0);
      Reset = 1'b1; set_alarm = 1'b0;
      step(1);
      set_time = 1'b1; mode_12h = 1'b1;
      repeat (13) pulse_hour();
      chk("h13_12h", disp_hour, 1);
      chk("h13_pm", pm, 1);
      set_time = 1'b0;
      step(1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
